circular_tap_buffer: RTL

Parametrised circular buffer with write-enable, synchronous flush, fill tracking and an age-ordered tapped view of its contents. Storage is a word array addressed by a wrapping write pointer; outputs are presented as if the buffer were a shift register, newest sample first, so it drops in wherever the fixed 4×8 circular buffers sit today (sample delay lines, FIR tap stores) and adds depth/width generality, gated writes and a random-access tap.

---
 rtl/circular_tap_buffer.sv | 76 +++++++
 1 files changed

// File: rtl/circular_tap_buffer.sv
// Parametrised circular buffer with gated writes, synchronous flush and fill tracking.
// Contents are presented newest-first, as if the storage were a shift register.
module circular_tap_buffer #(
  parameter int word_size = 8,
  parameter int buff_size = 4,
  parameter int ptr_size  = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [word_size-1:0]           Data_in,
  input  logic                           shift_en,
  input  logic                           flush,
  input  logic [ptr_size-1:0]            tap_sel,
  output logic [buff_size*word_size-1:0] cells_flat,
  output logic [word_size-1:0]           tap_out,
  output logic [ptr_size:0]              fill_count,
  output logic                           full,
  output logic                           wrap
);

  localparam logic [ptr_size:0]   BUFF = (ptr_size+1)'(buff_size);
  localparam logic [ptr_size-1:0] LAST = ptr_size'(buff_size - 1);

  logic [word_size-1:0] mem    [buff_size];
  logic [word_size-1:0] slices [buff_size];
  logic [ptr_size-1:0]  wp;
  logic [ptr_size:0]    count;
  logic                 wrap_q;
  logic [ptr_size:0]    idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < buff_size; i++) mem[i] <= '0;
      wp     <= '0;
      count  <= '0;
      wrap_q <= 1'b0;
    end else if (flush) begin
      for (int unsigned i = 0; i < buff_size; i++) mem[i] <= '0;
      wp     <= '0;
      count  <= '0;
      wrap_q <= 1'b0;
    end else if (shift_en) begin
      mem[wp] <= Data_in;
      wp      <= (wp == LAST) ? '0 : wp + 1'b1;
      if (count != BUFF) count <= count + 1'b1;
      wrap_q  <= (wp == LAST);
    end else begin
      wrap_q <= 1'b0;
    end
  end

  // Age k lives at (wp-1-k) mod buff_size; bias by buff_size in a wider
  // intermediate so the subtraction never underflows for non-power-of-two depths.
  always_comb begin
    idx = '0;
    for (int unsigned k = 0; k < buff_size; k++) begin
      idx = {1'b0, wp} + (ptr_size+1)'(buff_size - 1 - k);
      if (idx >= BUFF) idx = idx - BUFF;
      slices[k] = mem[idx[ptr_size-1:0]];
    end
  end

  always_comb begin
    cells_flat = '0;
    tap_out    = '0;
    for (int unsigned k = 0; k < buff_size; k++) begin
      cells_flat[k*word_size +: word_size] = slices[k];
      if (tap_sel == ptr_size'(k)) tap_out = slices[k];
    end
  end

  assign fill_count = count;
  assign full       = (count == BUFF);
  assign wrap       = wrap_q;

endmodule
